// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and lamp/phase outputs of the traffic phase scheduler.
// The master side drives requests; the slave side (the scheduler) drives lamps.
interface traffic_phase_scheduler_if;
    logic       side_req;
    logic       ped_req;
    logic       emg_req;
    logic [2:0] light_main;
    logic [2:0] light_side;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output side_req, ped_req, emg_req,
        input  light_main, light_side, walk, phase
    );

    modport slave (
        input  side_req, ped_req, emg_req,
        output light_main, light_side, walk, phase
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Main/side road intersection controller with pedestrian walk and emergency preempt.
// Lamps and phase are registered copies of the decoded next state, so they always match the state register.
module traffic_phase_scheduler #(
    parameter int T_MIN_GREEN  = 4,
    parameter int T_YELLOW     = 3,
    parameter int T_ALLRED     = 1,
    parameter int T_SIDE_GREEN = 6,
    parameter int T_PED        = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    traffic_phase_scheduler_if.slave   bus
);
    localparam int T_MAX_A = (T_MIN_GREEN > T_YELLOW) ? T_MIN_GREEN : T_YELLOW;
    localparam int T_MAX_B = (T_ALLRED > T_SIDE_GREEN) ? T_ALLRED : T_SIDE_GREEN;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_PED) ? T_MAX_C : T_PED;
    localparam int TW      = $clog2(T_MAX + 2);

    localparam logic [TW-1:0] C_MG = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] C_Y  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] C_AR = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] C_SG = TW'(T_SIDE_GREEN - 1);
    localparam logic [TW-1:0] C_PD = TW'(T_PED - 1);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_X    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_M    = 3'd5,
        PED_WALK    = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic            r_side_pend;
    logic            r_ped_pend;
    logic            w_side_pend_next;
    logic            w_ped_pend_next;
    logic [2:0]      r_light_main;
    logic [2:0]      r_light_side;
    logic            r_walk;
    logic [2:0]      r_phase;

    function automatic logic [2:0] decode_main(input state_t s);
        case (s)
            MAIN_GREEN:  decode_main = 3'b001;
            MAIN_YELLOW: decode_main = 3'b010;
            default:     decode_main = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] decode_side(input state_t s);
        case (s)
            SIDE_GREEN:  decode_side = 3'b001;
            SIDE_YELLOW: decode_side = 3'b010;
            default:     decode_side = 3'b100;
        endcase
    endfunction

    // Next-state selection, dwell timer and request latch updates.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_GREEN: begin
                if ((r_side_pend || r_ped_pend) && (r_timer >= C_MG) && !bus.emg_req) begin
                    w_next = MAIN_YELLOW;
                end else begin
                    w_next = MAIN_GREEN;
                end
            end
            MAIN_YELLOW: begin
                if (r_timer >= C_Y) w_next = ALLRED_X;
                else                w_next = MAIN_YELLOW;
            end
            ALLRED_X: begin
                // Preempt returns to main green without consuming pending requests.
                if (r_timer >= C_AR) begin
                    if (bus.emg_req)     w_next = MAIN_GREEN;
                    else if (r_ped_pend) w_next = PED_WALK;
                    else                 w_next = SIDE_GREEN;
                end else begin
                    w_next = ALLRED_X;
                end
            end
            SIDE_GREEN: begin
                if (bus.emg_req || (r_timer >= C_SG)) w_next = SIDE_YELLOW;
                else                                  w_next = SIDE_GREEN;
            end
            SIDE_YELLOW: begin
                if (r_timer >= C_Y) w_next = ALLRED_M;
                else                w_next = SIDE_YELLOW;
            end
            PED_WALK: begin
                if (bus.emg_req || (r_timer >= C_PD)) w_next = ALLRED_M;
                else                                  w_next = PED_WALK;
            end
            ALLRED_M: begin
                if (r_timer >= C_AR) w_next = MAIN_GREEN;
                else                 w_next = ALLRED_M;
            end
            default: w_next = MAIN_GREEN;
        endcase

        if (w_next != r_state)            w_timer_next = {TW{1'b0}};
        else if (r_timer != {TW{1'b1}})   w_timer_next = r_timer + {{(TW-1){1'b0}}, 1'b1};
        else                              w_timer_next = r_timer;

        if ((w_next == SIDE_GREEN) && (r_state != SIDE_GREEN)) w_side_pend_next = 1'b0;
        else                                                   w_side_pend_next = r_side_pend | bus.side_req;

        if ((w_next == PED_WALK) && (r_state != PED_WALK)) w_ped_pend_next = 1'b0;
        else                                               w_ped_pend_next = r_ped_pend | bus.ped_req;
    end

    // State, timer, latches and registered lamp decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= MAIN_GREEN;
            r_timer      <= {TW{1'b0}};
            r_side_pend  <= 1'b0;
            r_ped_pend   <= 1'b0;
            r_light_main <= 3'b001;
            r_light_side <= 3'b100;
            r_walk       <= 1'b0;
            r_phase      <= 3'd0;
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer_next;
            r_side_pend  <= w_side_pend_next;
            r_ped_pend   <= w_ped_pend_next;
            r_light_main <= decode_main(w_next);
            r_light_side <= decode_side(w_next);
            r_walk       <= (w_next == PED_WALK);
            r_phase      <= w_next;
        end
    end

    assign bus.light_main = r_light_main;
    assign bus.light_side = r_light_side;
    assign bus.walk       = r_walk;
    assign bus.phase      = r_phase;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scenario bench for traffic_phase_scheduler: expected phases are queued as stimulus is driven
// and compared, together with the lamp decode, after each rising edge.
module tb_traffic_phase_scheduler;
    localparam int T_MG = 4;
    localparam int T_Y  = 3;
    localparam int T_AR = 1;
    localparam int T_SG = 6;
    localparam int T_PD = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .T_MIN_GREEN(T_MG), .T_YELLOW(T_Y), .T_ALLRED(T_AR),
        .T_SIDE_GREEN(T_SG), .T_PED(T_PD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [2:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int step_no = 0;
    string scen = "init";

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s step %0d: got %0h expected %0h", scen, tag, step_no, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_main(input logic [2:0] p);
        case (p)
            3'd0:    exp_main = 3'b001;
            3'd1:    exp_main = 3'b010;
            default: exp_main = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] p);
        case (p)
            3'd3:    exp_side = 3'b001;
            3'd4:    exp_side = 3'b010;
            default: exp_side = 3'b100;
        endcase
    endfunction

    // One clock: drive inputs, queue the phase expected after the edge, then compare.
    task automatic step(input logic r, input logic s, input logic p, input logic e,
                        input logic [2:0] exp_phase);
        logic [2:0] x;
        @(negedge clk);
        rst = r;
        bus.side_req = s;
        bus.ped_req  = p;
        bus.emg_req  = e;
        exp_q.push_back(exp_phase);
        @(posedge clk);
        #1;
        step_no++;
        if (exp_q.size() == 0) begin
            check("queue", 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            check("phase", {29'd0, bus.phase}, {29'd0, x});
            check("main",  {29'd0, bus.light_main}, {29'd0, exp_main(x)});
            check("side",  {29'd0, bus.light_side}, {29'd0, exp_side(x)});
            check("walk",  {31'd0, bus.walk}, {31'd0, (x == 3'd6)});
        end
    endtask

    task automatic run(input logic [2:0] exp_phase, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, exp_phase);
    endtask

    task automatic do_reset(input string name);
        scen = name;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic to_allred_x;
        run(3'd0, T_MG - 2);
        run(3'd1, T_Y);
        run(3'd2, T_AR);
    endtask

    task automatic side_service;
        run(3'd3, T_SG);
        run(3'd4, T_Y);
        run(3'd5, T_AR);
    endtask

    initial begin
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        bus.emg_req  = 1'b0;

        do_reset("idle");
        run(3'd0, 50);

        do_reset("side");
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        to_allred_x();
        side_service();
        run(3'd0, 15);

        do_reset("side_ped");
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        to_allred_x();
        run(3'd6, T_PD);
        run(3'd5, T_AR);
        run(3'd0, T_MG);
        run(3'd1, T_Y);
        run(3'd2, T_AR);
        side_service();
        run(3'd0, 10);

        do_reset("emg_side_green");
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        to_allred_x();
        run(3'd3, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
        run(3'd4, T_Y - 1);
        run(3'd5, T_AR);
        run(3'd0, 10);

        do_reset("emg_hold_main");
        for (int i = 0; i < 20; i++) step(1'b0, (i == 0), 1'b0, 1'b1, 3'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        run(3'd1, T_Y - 1);
        run(3'd2, T_AR);
        side_service();
        run(3'd0, 5);

        do_reset("emg_allred_x");
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        run(3'd0, T_MG - 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        for (int i = 0; i < T_Y - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        run(3'd0, T_MG - 1);
        run(3'd1, T_Y);
        run(3'd2, T_AR);
        side_service();
        run(3'd0, 3);

        do_reset("emg_ped");
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        to_allred_x();
        run(3'd6, 2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        run(3'd0, 8);

        do_reset("rst_mid_side");
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        to_allred_x();
        run(3'd3, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
        run(3'd3, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        run(3'd0, 15);

        do_reset("rst_mid_ped");
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        to_allred_x();
        run(3'd6, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        run(3'd0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter T_MIN_GREEN, default 4: minimum main-green dwell, in cycles.
REQ-002 Parameter T_YELLOW, default 3: yellow dwell, in cycles, for both roads.
REQ-003 Parameter T_ALLRED, default 1: all-red clearance dwell, in cycles.
REQ-004 Parameter T_SIDE_GREEN, default 6: side-green dwell, in cycles.
REQ-005 Parameter T_PED, default 5: pedestrian-walk dwell, in cycles.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 side_req  input  1  side-road vehicle sensor, level or pulse.
REQ-009 ped_req  input  1  pedestrian push-button, level or pulse.
REQ-010 emg_req  input  1  emergency preempt, level, favours the main road.
REQ-011 light_main  output  3  main-road lamp {red,yellow,green}, one-hot.
REQ-012 light_side  output  3  side-road lamp {red,yellow,green}, one-hot.
REQ-013 walk  output  1  pedestrian walk lamp.
REQ-014 phase  output  3  current state code.

Function
REQ-015 States and codes: MAIN_GREEN=0, MAIN_YELLOW=1, ALLRED_X=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALLRED_M=5, PED_WALK=6; codes 7 and above are illegal and SHALL go to MAIN_GREEN on the next edge.
REQ-016 Outputs SHALL be a pure decode of the registered state, with no combinational path from the inputs.
REQ-017 light_main SHALL be 001 in MAIN_GREEN, 010 in MAIN_YELLOW, and 100 otherwise.
REQ-018 light_side SHALL be 001 in SIDE_GREEN, 010 in SIDE_YELLOW, and 100 otherwise.
REQ-019 walk SHALL be 1 only in PED_WALK.
REQ-020 A dwell timer SHALL clear to 0 on every state entry, increment each cycle, and saturate at its maximum value while in MAIN_GREEN.
REQ-021 Sticky latches side_pend and ped_pend SHALL set on any cycle where their input is 1.
REQ-022 side_pend SHALL clear on entry to SIDE_GREEN, and ped_pend SHALL clear on entry to PED_WALK; a request present on the entry cycle is absorbed and not re-latched.
REQ-023 MAIN_GREEN -> MAIN_YELLOW when (side_pend or ped_pend) and timer >= T_MIN_GREEN-1 and emg_req=0; otherwise MAIN_GREEN holds.
REQ-024 MAIN_YELLOW -> ALLRED_X after T_YELLOW cycles.
REQ-025 ALLRED_X exit after T_ALLRED cycles: to MAIN_GREEN if emg_req=1 (latches kept), else to PED_WALK if ped_pend, else to SIDE_GREEN.
REQ-026 Pedestrian service SHALL have priority over side-road service when both latches are set.
REQ-027 SIDE_GREEN -> SIDE_YELLOW after T_SIDE_GREEN cycles, or on the next edge if emg_req=1.
REQ-028 SIDE_YELLOW -> ALLRED_M after T_YELLOW cycles; emg_req SHALL NOT shorten yellow.
REQ-029 PED_WALK -> ALLRED_M after T_PED cycles, or on the next edge if emg_req=1.
REQ-030 ALLRED_M -> MAIN_GREEN after T_ALLRED cycles.
REQ-031 Main and side SHALL never be simultaneously non-red, and walk=1 SHALL imply both roads red.
REQ-032 The timer SHALL be wide enough for the largest parameter plus 1; every parameter SHALL be >= 1.

Reset
REQ-033 rst=1 on an edge SHALL force: state MAIN_GREEN, timer 0, side_pend=0, ped_pend=0; outputs light_main=001, light_side=100, walk=0, phase=0.
REQ-034 Reset SHALL take precedence over all requests and SHALL abort any phase immediately, including mid-SIDE_GREEN and mid-PED_WALK.

Verification
REQ-035 Reset, then no requests for 50 cycles -> phase=0 and light_main=001 throughout.
REQ-036 side_req pulsed 1 cycle after reset release -> MAIN_GREEN 4 cycles, MAIN_YELLOW 3, ALLRED_X 1, SIDE_GREEN 6 (light_side=001), SIDE_YELLOW 3, ALLRED_M 1, then phase=0 indefinitely.
REQ-037 side_req and ped_req asserted in the same cycle -> PED_WALK first (walk=1 for 5 cycles, both lamps 100), ALLRED_M, MAIN_GREEN for 4 cycles, then side service.
REQ-038 emg_req asserted for 1 cycle at SIDE_GREEN timer=2 -> SIDE_YELLOW on the next edge, full 3-cycle yellow, ALLRED_M, MAIN_GREEN; side_pend=0.
REQ-039 emg_req held high in MAIN_GREEN with side_pend=1 for 20 cycles -> phase stays 0; on emg_req release, MAIN_YELLOW on the next edge.
REQ-040 rst pulsed at SIDE_GREEN timer=3 with ped_pend=1 -> next cycle phase=0, light_main=001, ped_pend=0, and no further transition without a new request.
